branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Sits between fetch and execute. Records every fetched instruction's PC and predicted next PC in program order.
- Compares each prediction against the in-order resolution result from execute.
- Drives the BTB training interface (update/committed/current/target).
- On a wrong prediction, issues a one-cycle pipeline flush with the correct redirect PC.

Parameters:
- ADDR_W, 32, address width of all PC/target buses.
- DEPTH, 4, in-flight prediction FIFO entries; power of two, at least 2.
- CNT_W, 32, width of the performance counters.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- push_valid  input  1  fetch presents a new instruction prediction
- push_pc  input  ADDR_W  PC of the fetched instruction
- push_pred_taken  input  1  BTB prediction bit for that PC
- push_pred_next  input  ADDR_W  next PC chosen by fetch (BTB target or pc+4)
- push_ready  output  1  entry can be accepted this cycle
- res_valid  input  1  execute resolves the oldest in-flight instruction
- res_is_branch  input  1  instruction is a conditional branch/jump
- res_taken  input  1  actual branch outcome (ignored if !res_is_branch)
- res_target  input  ADDR_W  actual taken target
- res_ready  output  1  resolution can be accepted this cycle
- update  output  1  one-cycle BTB training strobe
- committed  output  1  actual outcome sent with update (1 = taken)
- current  output  ADDR_W  PC being trained
- target  output  ADDR_W  taken target being trained
- flush  output  1  one-cycle mispredict flush
- flush_pc  output  ADDR_W  redirect PC, valid while flush=1
- branch_cnt  output  CNT_W  resolved entries that produced an update
- mispred_cnt  output  CNT_W  flushes issued

Behaviour:
- Reset:
  - FIFO empty (rd_ptr = wr_ptr = 0, count = 0); state RUN.
  - update, committed, current, target, flush, flush_pc, branch_cnt and mispred_cnt all 0.
  - Reset mid-operation drops all entries and emits no update or flush.
- States: RUN and FLUSH.
- Handshakes: push fires on push_valid && push_ready; resolution fires on res_valid && res_ready.
- Ready signals:
  - push_ready = (state==RUN) && (count<DEPTH).
  - res_ready = (state==RUN) && (count!=0).
  - Neither depends combinationally on push_valid or res_valid.
- Push: write {pc, pred_taken, pred_next} at wr_ptr. Pointers wrap modulo DEPTH.
- Resolution fire: pop the head entry and compute:
  - actual_next = (res_is_branch && res_taken) ? res_target : head.pc+4, modulo 2^ADDR_W.
  - mispredict = actual_next != head.pred_next.
- Training: train = res_is_branch || head.pred_taken.
  - A non-branch predicted taken is an alias; it trains with committed=0 so the BTB counter decays.
  - If train, at the next edge: update<=1, committed<=res_is_branch&&res_taken, current<=head.pc, target<=res_target (or head.pc+4 when !res_is_branch), branch_cnt+1.
  - Otherwise update<=0.
  - update is a single-cycle pulse, 1-cycle latency from the resolution fire.
- No mispredict: a simultaneous push and pop both take effect, and count is unchanged.
- Mispredict, on the same edge:
  - FIFO cleared (rd_ptr = wr_ptr, count = 0).
  - Any push firing that cycle is discarded as wrong-path.
  - flush<=1, flush_pc<=actual_next, mispred_cnt+1, state<=FLUSH.
  - The training pulse is issued in the same cycle as flush.
- FLUSH: lasts exactly one cycle with both readys low, then returns to RUN. flush drops to 0.
- Counters wrap modulo 2^CNT_W.
- Full FIFO: push_ready=0 even when a pop occurs that cycle. No bypass.
- Empty FIFO: res_ready=0, and res_valid is ignored.
- Outputs current, target and flush_pc hold their last values while their strobes are low.

Test Plan:
- Reset then push pc=0x100, pred_next=0x104; resolve non-branch -> no update, no flush, count returns to 0, branch_cnt=0.
- Push pc=0x200, pred_taken=1, pred_next=0x280; resolve branch taken target 0x280 -> next cycle update=1, committed=1, current=0x200, target=0x280, flush=0.
- Push 0x300 (pred_next=0x304), then 0x304 and 0x308; resolve 0x300 as branch taken to 0x400 ->
  - update=1, committed=1, flush=1, flush_pc=0x400.
  - FIFO empty, push_ready=0 for one cycle, mispred_cnt=1.
- Push pc=0x500 with pred_taken=1, pred_next=0x540; resolve non-branch ->
  - update=1, committed=0, current=0x500, target=0x504.
  - flush=1, flush_pc=0x504.
- Fill 4 entries: push_ready=0. Then simultaneous pop and push_valid: push not accepted that cycle; accepted the next cycle. Entries resolve in FIFO order across pointer wrap.
- Assert reset with 3 entries in flight and a resolution firing -> no update/flush pulse afterwards; counters 0, FIFO empty.

Source files
------------

// File: rtl/branch_resolver.sv
// Tracks in-flight fetch predictions in order and checks them against execute.
// Trains the BTB on every resolved branch or alias and flushes on mispredicts.
module branch_resolver #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              push_pred_taken,
    input  logic [ADDR_W-1:0] push_pred_next,
    output logic              push_ready,
    input  logic              res_valid,
    input  logic              res_is_branch,
    input  logic              res_taken,
    input  logic [ADDR_W-1:0] res_target,
    output logic              res_ready,
    output logic              update,
    output logic              committed,
    output logic [ADDR_W-1:0] current,
    output logic [ADDR_W-1:0] target,
    output logic              flush,
    output logic [ADDR_W-1:0] flush_pc,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   L_FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] L_ONE  = PW'(1);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc [DEPTH];
    logic [ADDR_W-1:0] r_pn [DEPTH];
    logic              r_pt [DEPTH];
    logic [PW-1:0]     r_rd;
    logic [PW-1:0]     r_wr;
    logic [PW:0]       r_count;

    logic              w_push;
    logic              w_pop;
    logic              w_mis;
    logic              w_train;
    logic              w_taken;
    logic [ADDR_W-1:0] w_head_pc;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_actual;
    logic [ADDR_W-1:0] w_trn_tgt;

    assign push_ready = (r_state == S_RUN) && (r_count < L_FULL);
    assign res_ready  = (r_state == S_RUN) && (r_count != '0);

    assign w_push    = push_valid && push_ready;
    assign w_pop     = res_valid && res_ready;
    assign w_head_pc = r_pc[r_rd];
    assign w_seq_pc  = w_head_pc + ADDR_W'(4);
    assign w_taken   = res_is_branch && res_taken;
    assign w_actual  = w_taken ? res_target : w_seq_pc;
    assign w_mis     = w_pop && (w_actual != r_pn[r_rd]);
    // Non-branches predicted taken are aliases and still train (as not-taken).
    assign w_train   = w_pop && (res_is_branch || r_pt[r_rd]);
    assign w_trn_tgt = res_is_branch ? res_target : w_seq_pc;

    always_ff @(posedge clock) begin
        if (w_push && !w_mis) begin
            r_pc[r_wr] <= push_pc;
            r_pn[r_wr] <= push_pred_next;
            r_pt[r_wr] <= push_pred_taken;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_rd        <= '0;
            r_wr        <= '0;
            r_count     <= '0;
            update      <= 1'b0;
            committed   <= 1'b0;
            current     <= '0;
            target      <= '0;
            flush       <= 1'b0;
            flush_pc    <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            update <= w_train;
            flush  <= 1'b0;
            if (w_train) begin
                committed  <= w_taken;
                current    <= w_head_pc;
                target     <= w_trn_tgt;
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            unique case (r_state)
                S_RUN: begin
                    if (w_mis) begin
                        // Wrong-path push this cycle is dropped with the rest.
                        r_rd        <= r_wr;
                        r_count     <= '0;
                        flush       <= 1'b1;
                        flush_pc    <= w_actual;
                        mispred_cnt <= mispred_cnt + CNT_W'(1);
                        r_state     <= S_FLUSH;
                    end else begin
                        if (w_push) r_wr <= r_wr + L_ONE;
                        if (w_pop)  r_rd <= r_rd + L_ONE;
                        r_count <= r_count + {{PW{1'b0}}, w_push}
                                           - {{PW{1'b0}}, w_pop};
                    end
                end
                S_FLUSH: r_state <= S_RUN;
                default: r_state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed vector bench for branch_resolver.
// Each row drives one cycle and checks outputs just after the edge.
module tb_branch_resolver;

    logic        clock = 1'b0;
    logic        reset;
    logic        push_valid;
    logic [31:0] push_pc;
    logic        push_pred_taken;
    logic [31:0] push_pred_next;
    logic        push_ready;
    logic        res_valid;
    logic        res_is_branch;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_ready;
    logic        update;
    logic        committed;
    logic [31:0] current;
    logic [31:0] target;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int n_vec = 0;
    int n_err = 0;

    branch_resolver dut (
        .clock           (clock),
        .reset           (reset),
        .push_valid      (push_valid),
        .push_pc         (push_pc),
        .push_pred_taken (push_pred_taken),
        .push_pred_next  (push_pred_next),
        .push_ready      (push_ready),
        .res_valid       (res_valid),
        .res_is_branch   (res_is_branch),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .res_ready       (res_ready),
        .update          (update),
        .committed       (committed),
        .current         (current),
        .target          (target),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .branch_cnt      (branch_cnt),
        .mispred_cnt     (mispred_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        ppt;
        logic [31:0] ppn;
        logic        rv;
        logic        rb;
        logic        rt;
        logic [31:0] rtg;
        logic        pr;
        logic        rr;
        logic        upd;
        logic        com;
        logic [31:0] cur;
        logic [31:0] tgt;
        logic        fl;
        logic [31:0] fpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } vec_t;

    vec_t vq[$];

    task automatic add(
        input logic pv, input logic [31:0] ppc, input logic ppt,
        input logic [31:0] ppn, input logic rv, input logic rb,
        input logic rt, input logic [31:0] rtg, input logic pr,
        input logic rr, input logic upd, input logic com,
        input logic [31:0] cur, input logic [31:0] tgt, input logic fl,
        input logic [31:0] fpc, input logic [31:0] bc,
        input logic [31:0] mc);
        vec_t v;
        v.pv = pv;   v.ppc = ppc; v.ppt = ppt; v.ppn = ppn;
        v.rv = rv;   v.rb = rb;   v.rt = rt;   v.rtg = rtg;
        v.pr = pr;   v.rr = rr;   v.upd = upd; v.com = com;
        v.cur = cur; v.tgt = tgt; v.fl = fl;   v.fpc = fpc;
        v.bc = bc;   v.mc = mc;
        vq.push_back(v);
    endtask

    task automatic chk(input int id, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL v%0d %s: got %h want %h", id, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        push_valid      = v.pv;
        push_pc         = v.ppc;
        push_pred_taken = v.ppt;
        push_pred_next  = v.ppn;
        res_valid       = v.rv;
        res_is_branch   = v.rb;
        res_taken       = v.rt;
        res_target      = v.rtg;
    endtask

    task automatic check_vec(input int id, input vec_t v);
        n_vec++;
        chk(id, "push_ready", 32'(push_ready), 32'(v.pr));
        chk(id, "res_ready", 32'(res_ready), 32'(v.rr));
        chk(id, "update", 32'(update), 32'(v.upd));
        chk(id, "flush", 32'(flush), 32'(v.fl));
        chk(id, "branch_cnt", branch_cnt, v.bc);
        chk(id, "mispred_cnt", mispred_cnt, v.mc);
        if (v.upd) begin
            chk(id, "committed", 32'(committed), 32'(v.com));
            chk(id, "current", current, v.cur);
            chk(id, "target", target, v.tgt);
        end
        if (v.fl) chk(id, "flush_pc", flush_pc, v.fpc);
    endtask

    task automatic check_reset_state(input int id);
        n_vec++;
        chk(id, "rst push_ready", 32'(push_ready), 32'd1);
        chk(id, "rst res_ready", 32'(res_ready), 32'd0);
        chk(id, "rst update", 32'(update), 32'd0);
        chk(id, "rst committed", 32'(committed), 32'd0);
        chk(id, "rst current", current, 32'd0);
        chk(id, "rst target", target, 32'd0);
        chk(id, "rst flush", 32'(flush), 32'd0);
        chk(id, "rst flush_pc", flush_pc, 32'd0);
        chk(id, "rst branch_cnt", branch_cnt, 32'd0);
        chk(id, "rst mispred_cnt", mispred_cnt, 32'd0);
    endtask

    initial begin
        vec_t idle;
        idle = '{default: '0};
        // pv ppc pt ppn | rv rb rt rtg | pr rr upd com cur tgt fl fpc bc mc
        add(1,'h100,0,'h104, 0,0,0,0,      1,1,0,0,0,0,0,0,0,0);
        add(0,0,0,0,         1,0,0,0,      1,0,0,0,0,0,0,0,0,0);
        add(1,'h200,1,'h280, 0,0,0,0,      1,1,0,0,0,0,0,0,0,0);
        add(0,0,0,0,         1,1,1,'h280,  1,0,1,1,'h200,'h280,0,0,1,0);
        add(0,0,0,0,         1,1,1,'h123,  1,0,0,0,0,0,0,0,1,0);
        add(1,'h300,0,'h304, 0,0,0,0,      1,1,0,0,0,0,0,0,1,0);
        add(1,'h304,0,'h308, 0,0,0,0,      1,1,0,0,0,0,0,0,1,0);
        add(1,'h308,0,'h30c, 0,0,0,0,      1,1,0,0,0,0,0,0,1,0);
        add(1,'h30c,0,'h310, 1,1,1,'h400,  0,0,1,1,'h300,'h400,1,'h400,2,1);
        add(1,'h400,0,'h404, 0,0,0,0,      1,0,0,0,0,0,0,0,2,1);
        add(1,'h500,1,'h540, 0,0,0,0,      1,1,0,0,0,0,0,0,2,1);
        add(0,0,0,0,         1,0,0,0,      0,0,1,0,'h500,'h504,1,'h504,3,2);
        add(0,0,0,0,         0,0,0,0,      1,0,0,0,0,0,0,0,3,2);
        add(1,'h600,0,'h604, 0,0,0,0,      1,1,0,0,0,0,0,0,3,2);
        add(1,'h604,0,'h608, 0,0,0,0,      1,1,0,0,0,0,0,0,3,2);
        add(1,'h608,0,'h60c, 0,0,0,0,      1,1,0,0,0,0,0,0,3,2);
        add(1,'h60c,0,'h610, 0,0,0,0,      0,1,0,0,0,0,0,0,3,2);
        add(1,'h610,0,'h614, 1,0,0,0,      1,1,0,0,0,0,0,0,3,2);
        add(1,'h610,0,'h614, 1,0,0,0,      1,1,0,0,0,0,0,0,3,2);
        add(0,0,0,0,         1,1,0,'h700,  1,1,1,0,'h608,'h700,0,0,4,2);
        add(0,0,0,0,         1,0,0,0,      1,1,0,0,0,0,0,0,4,2);
        add(0,0,0,0,         1,1,1,'h614,  1,0,1,1,'h610,'h614,0,0,5,2);
        add(1,'h800,0,'h804, 0,0,0,0,      1,1,0,0,0,0,0,0,5,2);
        add(1,'h804,0,'h808, 0,0,0,0,      1,1,0,0,0,0,0,0,5,2);
        add(1,'h808,0,'h80c, 0,0,0,0,      1,1,0,0,0,0,0,0,5,2);

        drive(idle);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_reset_state(0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(posedge clock);
            #1;
            check_vec(i + 1, vq[i]);
        end

        // Reset lands on a cycle where a mispredicting resolution would fire.
        push_valid = 1'b1;  push_pc = 32'h80c; push_pred_next = 32'h810;
        res_valid = 1'b1;   res_is_branch = 1'b1;
        res_taken = 1'b1;   res_target = 32'h900;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_state(100);
        reset = 1'b0;
        push_valid = 1'b0;
        @(posedge clock);
        #1;
        check_reset_state(101);

        drive(idle);
        push_valid = 1'b1; push_pc = 32'h900; push_pred_next = 32'h904;
        @(posedge clock);
        #1;
        n_vec++;
        chk(102, "post-rst res_ready", 32'(res_ready), 32'd1);
        drive(idle);
        res_valid = 1'b1;
        @(posedge clock);
        #1;
        n_vec++;
        chk(103, "post-rst res_ready", 32'(res_ready), 32'd0);
        chk(103, "post-rst update", 32'(update), 32'd0);
        chk(103, "post-rst flush", 32'(flush), 32'd0);
        drive(idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
